// File: rtl/seg7_multi_display.sv
// N-digit active-low 7-segment controller: latches a value, shows it in hex or decimal
// (sequential double-dabble), with leading-zero blanking, decimal points and overflow dashes.
// Optional per-digit blinking is compiled in when SEG7_BLINK_EN is defined.
module seg7_multi_display #(
    parameter int NUM_DIGITS = 6,
    parameter int DATA_W     = 20,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_i,
    input  logic [DATA_W-1:0]       data_i,
    input  logic                    mode_i,
    input  logic                    lzb_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
`ifdef SEG7_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_i,
`endif
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    ovf_o,
    output logic [8*NUM_DIGITS-1:0] seg_o
);

    localparam int BCD_W = 4*NUM_DIGITS + 4;
    localparam int EXT_W = 4*NUM_DIGITS + DATA_W;
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || DATA_W < 4 || DATA_W > 32 || BLINK_DIV < 1) begin : g_param_check
        $error("seg7_multi_display: parameter out of range");
    end

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_UPDATE} state_t;

    state_t                  r_state;
    logic [DATA_W-1:0]       r_data;
    logic                    r_mode;
    logic                    r_lzb;
    logic [NUM_DIGITS-1:0]   r_dp;
    logic [BCD_W-1:0]        r_bcd;
    logic                    r_bcd_lost;
    logic [CNT_W-1:0]        r_cnt;
    logic [8*NUM_DIGITS-1:0] r_seg;
    logic                    r_done;
    logic                    r_ovf;

    logic [BCD_W-1:0]        w_bcd_adj;
    logic [EXT_W-1:0]        w_data_ext;
    logic [4*NUM_DIGITS-1:0] w_nib_flat;
    logic [NUM_DIGITS-1:0]   w_blank;
    logic                    w_ovf;
    logic [8*NUM_DIGITS-1:0] w_seg_new;

    function automatic logic [6:0] f_glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0011000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    function automatic logic [BCD_W-1:0] f_add3(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < NUM_DIGITS + 1; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign w_bcd_adj  = f_add3(r_bcd);
    assign w_data_ext = {{(4*NUM_DIGITS){1'b0}}, r_data};
    assign w_nib_flat = r_mode ? r_bcd[4*NUM_DIGITS-1:0] : w_data_ext[4*NUM_DIGITS-1:0];

    // A carry out of the top BCD digit means the value exceeded even the spare digit.
    assign w_ovf = r_mode ? ((|r_bcd[BCD_W-1:4*NUM_DIGITS]) | r_bcd_lost)
                          : (|w_data_ext[EXT_W-1:4*NUM_DIGITS]);

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        if (gi == 0) begin : g_first
            assign w_blank[gi] = 1'b0;
        end else begin : g_upper
            assign w_blank[gi] = r_lzb && ~|w_nib_flat[4*NUM_DIGITS-1:4*gi];
        end
        assign w_seg_new[8*gi +: 8] = w_ovf ? 8'hBF
            : {~r_dp[gi], w_blank[gi] ? 7'h7F : f_glyph(w_nib_flat[4*gi +: 4])};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_data     <= '0;
            r_mode     <= 1'b0;
            r_lzb      <= 1'b0;
            r_dp       <= '0;
            r_bcd      <= '0;
            r_bcd_lost <= 1'b0;
            r_cnt      <= '0;
            r_seg      <= '1;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load_i) begin
                        r_data     <= data_i;
                        r_mode     <= mode_i;
                        r_lzb      <= lzb_i;
                        r_dp       <= dp_i;
                        r_bcd      <= '0;
                        r_bcd_lost <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= mode_i ? S_CONVERT : S_UPDATE;
                    end
                end
                S_CONVERT: begin
                    // r_data doubles as the binary shift register in decimal mode.
                    r_bcd      <= {w_bcd_adj[BCD_W-2:0], r_data[DATA_W-1]};
                    r_bcd_lost <= r_bcd_lost | w_bcd_adj[BCD_W-1];
                    r_data     <= {r_data[DATA_W-2:0], 1'b0};
                    r_cnt      <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_LAST) r_state <= S_UPDATE;
                end
                S_UPDATE: begin
                    r_seg   <= w_seg_new;
                    r_ovf   <= w_ovf;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy_o = (r_state != S_IDLE);
    assign done_o = r_done;
    assign ovf_o  = r_ovf;

`ifdef SEG7_BLINK_EN
    localparam int BCW = $clog2(BLINK_DIV + 1);
    localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_DIV - 1);

    logic [BCW-1:0] r_blink_cnt;
    logic           r_blink_off;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_blink_off <= 1'b0;
        end else if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_blink_off <= ~r_blink_off;
        end else begin
            r_blink_cnt <= r_blink_cnt + BCW'(1);
        end
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_blink
        assign seg_o[8*gi +: 8] = (r_blink_off && blink_i[gi]) ? 8'hFF : r_seg[8*gi +: 8];
    end
`else
    assign seg_o = r_seg;
`endif

endmodule

// File: tb/tb_seg7_multi_display.sv
// Randomized self-checking bench for seg7_multi_display against an arithmetic display model.
module tb_seg7_multi_display;
    localparam int ND = 6;
    localparam int DW = 20;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            load_i = 1'b0;
    logic [DW-1:0]   data_i = '0;
    logic            mode_i = 1'b0;
    logic            lzb_i = 1'b0;
    logic [ND-1:0]   dp_i = '0;
    logic            busy_o;
    logic            done_o;
    logic            ovf_o;
    logic [8*ND-1:0] seg_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

`ifdef SEG7_BLINK_EN
    logic [ND-1:0] blink_i = '0;
    int n_edges = 0;
    always @(posedge clk) begin
        if (rst) n_edges <= 0;
        else     n_edges <= n_edges + 1;
    end

    seg7_multi_display #(.NUM_DIGITS(ND), .DATA_W(DW), .BLINK_DIV(4)) dut (
        .clk(clk), .rst(rst), .load_i(load_i), .data_i(data_i), .mode_i(mode_i),
        .lzb_i(lzb_i), .dp_i(dp_i), .blink_i(blink_i), .busy_o(busy_o),
        .done_o(done_o), .ovf_o(ovf_o), .seg_o(seg_o));
`else
    seg7_multi_display #(.NUM_DIGITS(ND), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .load_i(load_i), .data_i(data_i), .mode_i(mode_i),
        .lzb_i(lzb_i), .dp_i(dp_i), .busy_o(busy_o),
        .done_o(done_o), .ovf_o(ovf_o), .seg_o(seg_o));
`endif

    function automatic logic [6:0] glyph(input int n);
        case (n)
            0: return 7'b1000000;   1: return 7'b1111001;
            2: return 7'b0100100;   3: return 7'b0110000;
            4: return 7'b0011001;   5: return 7'b0010010;
            6: return 7'b0000010;   7: return 7'b1111000;
            8: return 7'b0000000;   9: return 7'b0011000;
            10: return 7'b0001000;  11: return 7'b0000011;
            12: return 7'b1000110;  13: return 7'b0100001;
            14: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    // Display contents computed from the value by plain division by powers of the radix.
    function automatic logic [8*ND-1:0] model_seg(input logic [31:0] d, input logic m,
                                                   input logic lzb, input logic [ND-1:0] dp,
                                                   output logic ovf);
        logic [8*ND-1:0] s;
        longint v, base, p, q;
        int dig;
        logic blank;
        v = longint'(d);
        base = m ? 10 : 16;
        p = 1;
        for (int i = 0; i < ND; i++) p = p * base;
        ovf = (v >= p);
        s = '1;
        p = 1;
        for (int k = 0; k < ND; k++) begin
            q = v / p;
            dig = int'(q % base);
            blank = lzb && (k > 0) && (q == 0);
            if (ovf) s[8*k +: 8] = 8'hBF;
            else     s[8*k +: 8] = {~dp[k], blank ? 7'h7F : glyph(dig)};
            p = p * base;
        end
        return s;
    endfunction

    task automatic do_load(input string name, input logic [DW-1:0] d, input logic m,
                           input logic lzb, input logic [ND-1:0] dp);
        logic [8*ND-1:0] exp_seg, prev;
        logic exp_ovf, held_ok;
        int lat, exp_lat;
        exp_seg = model_seg(32'(d), m, lzb, dp, exp_ovf);
        exp_lat = m ? DW + 2 : 2;
        @(negedge clk);
        prev = seg_o;
        data_i = d; mode_i = m; lzb_i = lzb; dp_i = dp; load_i = 1'b1;
        @(negedge clk);
        load_i = 1'b0;
        lat = 1;
        held_ok = 1'b1;
        checks++;
        if (busy_o !== 1'b1) begin
            failures++;
            $display("FAIL %s busy: got %b want 1", name, busy_o);
        end
        while (done_o !== 1'b1 && lat < 200) begin
            if (seg_o !== prev) held_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== exp_lat) begin
            failures++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        checks++;
        if (!held_ok) begin
            failures++;
            $display("FAIL %s seg_held: seg changed before done, want %h", name, prev);
        end
        checks++;
        if (seg_o !== exp_seg) begin
            failures++;
            $display("FAIL %s seg: got %h want %h", name, seg_o, exp_seg);
        end
        checks++;
        if (ovf_o !== exp_ovf) begin
            failures++;
            $display("FAIL %s ovf: got %b want %b", name, ovf_o, exp_ovf);
        end
        $display("load %s data=%h mode=%0d lzb=%0d dp=%b lat=%0d seg=%h ovf=%0d",
                 name, d, m, lzb, dp, lat, seg_o, ovf_o);
        @(negedge clk);
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL %s done_pulse: got done=%b busy=%b want 0/0", name, done_o, busy_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (seg_o !== 48'hFFFF_FFFF_FFFF || busy_o !== 1'b0 || done_o !== 1'b0 || ovf_o !== 1'b0) begin
            failures++;
            $display("FAIL reset: got seg=%h busy=%b done=%b ovf=%b want all-ones/0/0/0",
                     seg_o, busy_o, done_o, ovf_o);
        end
        $display("reset seg=%h busy=%b done=%b ovf=%b", seg_o, busy_o, done_o, ovf_o);
        rst = 1'b0;
    endtask

    task automatic test_hex();
        do_load("hex_a3f", 20'h00A3F, 1'b0, 1'b1, 6'b000010);
        checks++;
        if (seg_o !== 48'hFFFF_FF88_308E) begin
            failures++;
            $display("FAIL hex_a3f_const: got %h want %h", seg_o, 48'hFFFF_FF88_308E);
        end
        do_load("hex_nolzb", 20'h00A3F, 1'b0, 1'b0, 6'b100001);
        do_load("hex_max", 20'hFFFFF, 1'b0, 1'b1, 6'b111111);
    endtask

    task automatic test_decimal();
        do_load("dec_999999", 20'd999999, 1'b1, 1'b0, 6'b000000);
        checks++;
        if (seg_o !== 48'h9898_9898_9898) begin
            failures++;
            $display("FAIL dec_999999_const: got %h want %h", seg_o, 48'h9898_9898_9898);
        end
        do_load("dec_1000000", 20'd1000000, 1'b1, 1'b1, 6'b111111);
        checks++;
        if (seg_o !== 48'hBFBF_BFBF_BFBF || ovf_o !== 1'b1) begin
            failures++;
            $display("FAIL dec_ovf_const: got seg=%h ovf=%b want %h/1", seg_o, ovf_o, 48'hBFBF_BFBF_BFBF);
        end
        do_load("dec_max", 20'hFFFFF, 1'b1, 1'b0, 6'b000000);
    endtask

    task automatic test_zero();
        do_load("dec_zero_lzb", 20'd0, 1'b1, 1'b1, 6'b000000);
        checks++;
        if (seg_o !== 48'hFFFF_FFFF_FFC0) begin
            failures++;
            $display("FAIL zero_lzb_const: got %h want %h", seg_o, 48'hFFFF_FFFF_FFC0);
        end
        do_load("dec_zero", 20'd0, 1'b1, 1'b0, 6'b000000);
        checks++;
        if (seg_o !== 48'hC0C0_C0C0_C0C0) begin
            failures++;
            $display("FAIL zero_const: got %h want %h", seg_o, 48'hC0C0_C0C0_C0C0);
        end
        do_load("hex_zero_lzb", 20'd0, 1'b0, 1'b1, 6'b000001);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] a;
        logic [8*ND-1:0] exp_seg;
        logic exp_ovf;
        int n_done, lat, done_lat;
        a = DW'($urandom_range(0, 999999));
        exp_seg = model_seg(32'(a), 1'b1, 1'b1, 6'b000100, exp_ovf);
        @(negedge clk);
        data_i = a; mode_i = 1'b1; lzb_i = 1'b1; dp_i = 6'b000100; load_i = 1'b1;
        @(negedge clk);
        load_i = 1'b0;
        lat = 1; n_done = 0; done_lat = 0;
        repeat (3) begin @(negedge clk); lat++; end
        data_i = 20'h12345; mode_i = 1'b0; lzb_i = 1'b0; dp_i = '0; load_i = 1'b1;
        while (lat < DW + 20) begin
            @(negedge clk);
            lat++;
            load_i = 1'b0;
            if (done_o === 1'b1) begin n_done++; done_lat = lat; end
        end
        checks++;
        if (n_done !== 1 || done_lat !== DW + 2) begin
            failures++;
            $display("FAIL busy_load done: got count=%0d at %0d want 1 at %0d", n_done, done_lat, DW + 2);
        end
        checks++;
        if (seg_o !== exp_seg) begin
            failures++;
            $display("FAIL busy_load seg: got %h want %h", seg_o, exp_seg);
        end
        $display("busy_load data=%0d dones=%0d seg=%h", a, n_done, seg_o);
    endtask

    task automatic test_reset_mid();
        int n_done;
        do_load("pre_ovf", 20'd1000001, 1'b1, 1'b0, 6'b000000);
        @(negedge clk);
        data_i = 20'd123456; mode_i = 1'b1; lzb_i = 1'b0; dp_i = '0; load_i = 1'b1;
        @(negedge clk);
        load_i = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (seg_o !== 48'hFFFF_FFFF_FFFF || busy_o !== 1'b0 || done_o !== 1'b0 || ovf_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: got seg=%h busy=%b done=%b ovf=%b want all-ones/0/0/0",
                     seg_o, busy_o, done_o, ovf_o);
        end
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        repeat (30) begin
            @(negedge clk);
            if (done_o === 1'b1) n_done++;
        end
        checks++;
        if (n_done !== 0) begin
            failures++;
            $display("FAIL reset_mid_nodone: got %0d done pulses want 0", n_done);
        end
        $display("reset_mid seg=%h dones_after=%0d", seg_o, n_done);
    endtask

    task automatic test_random();
        logic [DW-1:0] d;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) == 0) d = DW'($urandom_range(0, 999));
            else                           d = DW'($urandom);
            do_load($sformatf("rnd%0d", i), d, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), ND'($urandom));
        end
    endtask

`ifdef SEG7_BLINK_EN
    task automatic test_blink();
        logic [8*ND-1:0] exp_seg, want;
        logic exp_ovf;
        logic [DW-1:0] d;
        d = DW'($urandom_range(0, 20'hFFFFF));
        do_load("blink_val", d, 1'b0, 1'b0, 6'b000011);
        exp_seg = model_seg(32'(d), 1'b0, 1'b0, 6'b000011, exp_ovf);
        blink_i = 6'b000001;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            want = exp_seg;
            if (((n_edges / 4) % 2) == 1) want[7:0] = 8'hFF;
            checks++;
            if (seg_o !== want) begin
                failures++;
                $display("FAIL blink cyc%0d: got %h want %h", i, seg_o, want);
            end
            $display("blink cyc%0d seg=%h", i, seg_o);
        end
        blink_i = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_hex();
        test_decimal();
        test_zero();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef SEG7_BLINK_EN
        test_blink();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
